// File: rtl/secuenciador_melodia.sv
// Melody sequencer: steps a fixed 16-entry song onto the 7-bit one-hot key bus of the tone generator.
// Latency: play/stop act on the next edge; teclas_in passes through to teclas one cycle later while idle.
// Backpressure: none; the downstream generator always accepts teclas, and play is ignored while busy.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   play, stop   start / abort requests (stop wins when both are high)
//   teclas_in    manual keys, forwarded to teclas when no song is playing
//   teclas       registered key bus (one-hot or zero during playback)
//   busy, done   registered playing flag and one-cycle end-of-song pulse
//   note_idx     registered index of the current song entry (0 when idle)
// Optional feature: define SECUENCIADOR_LOOP_EN to replay the song endlessly
// (done pulses at each wrap, busy stays high).
module secuenciador_melodia #(
  parameter int TICKS_PER_BEAT = 12_500_000,
  parameter int GAP_TICKS      = 250_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       stop,
  input  logic [6:0] teclas_in,
  output logic [6:0] teclas,
  output logic       busy,
  output logic       done,
  output logic [3:0] note_idx
);

  // One shared tick counter serves both the note beats and the gap.
  localparam int MAX_TICKS = (TICKS_PER_BEAT > GAP_TICKS) ? TICKS_PER_BEAT : GAP_TICKS;
  localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_BEAT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Song table, entry format {note[2:0], dur[2:0]}.
  function automatic logic [5:0] song_entry(input logic [3:0] i);
    logic [5:0] e;
    case (i)
      4'd0:    e = {3'd1, 3'd0};
      4'd1:    e = {3'd2, 3'd0};
      4'd2:    e = {3'd3, 3'd0};
      4'd3:    e = {3'd4, 3'd0};
      4'd4:    e = {3'd5, 3'd0};
      4'd5:    e = {3'd6, 3'd0};
      4'd6:    e = {3'd7, 3'd0};
      4'd7:    e = {3'd0, 3'd1};
      4'd8:    e = {3'd7, 3'd0};
      4'd9:    e = {3'd6, 3'd0};
      4'd10:   e = {3'd5, 3'd0};
      4'd11:   e = {3'd4, 3'd0};
      4'd12:   e = {3'd3, 3'd0};
      4'd13:   e = {3'd2, 3'd0};
      4'd14:   e = {3'd1, 3'd3};
      default: e = {3'd0, 3'd0};
    endcase
    return e;
  endfunction

  function automatic logic [2:0] entry_note(input logic [3:0] i);
    logic [5:0] e;
    e = song_entry(i);
    return e[5:3];
  endfunction

  function automatic logic [2:0] entry_dur(input logic [3:0] i);
    logic [5:0] e;
    e = song_entry(i);
    return e[2:0];
  endfunction

  // Note 1 is the top key; a rest (note 0) releases every key.
  function automatic logic [6:0] decode_note(input logic [2:0] n);
    logic [6:0] k;
    if (n == 3'd0) k = 7'd0;
    else           k = 7'b1000000 >> (n - 3'd1);
    return k;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    beat_q, beat_d;
  logic [6:0]    teclas_d;
  logic          busy_d, done_d;

  logic [2:0] cur_dur;
  logic       tick_end, beat_end, gap_end, song_end;

  assign cur_dur  = entry_dur(idx_q);
  assign tick_end = (tick_q == TICK_LAST);
  assign beat_end = (beat_q == cur_dur);
  assign gap_end  = (tick_q == GAP_LAST);
  // Last gap of the song expiring, not overridden by an abort.
  assign song_end = (state_q == S_GAP) && gap_end && (idx_q == 4'd15) && !stop;

  // State, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      tick_q  <= '0;
      beat_q  <= 3'd0;
      teclas  <= 7'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      beat_q  <= beat_d;
      teclas  <= teclas_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    beat_d  = beat_q;
    if (stop) begin
      state_d = S_IDLE;
      idx_d   = 4'd0;
      tick_d  = '0;
      beat_d  = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play) begin
            state_d = S_NOTE;
            idx_d   = 4'd0;
            tick_d  = '0;
            beat_d  = 3'd0;
          end
        end
        S_NOTE: begin
          if (tick_end) begin
            tick_d = '0;
            if (beat_end) begin
              state_d = S_GAP;
              beat_d  = 3'd0;
            end else begin
              beat_d = beat_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_end) begin
            tick_d = '0;
            if (idx_q != 4'd15) begin
              state_d = S_NOTE;
              idx_d   = idx_q + 4'd1;
            end else begin
`ifdef SECUENCIADOR_LOOP_EN
              state_d = S_NOTE;
`else
              state_d = S_IDLE;
`endif
              idx_d   = 4'd0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
          tick_d  = '0;
          beat_d  = 3'd0;
        end
      endcase
    end
  end

  // Output values are derived from the state being entered, so they land
  // on the same edge as the transition with no bubble cycle.
  always_comb begin
    teclas_d = 7'd0;
    busy_d   = 1'b0;
    done_d   = song_end;
    case (state_d)
      S_NOTE: begin
        teclas_d = decode_note(entry_note(idx_d));
        busy_d   = 1'b1;
      end
      S_GAP: begin
        teclas_d = 7'd0;
        busy_d   = 1'b1;
      end
      default: begin
        teclas_d = teclas_in;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign note_idx = idx_q;

endmodule

// File: tb/tb_secuenciador_melodia.sv
// Bench for secuenciador_melodia: timeline reference model plus directed and random stimulus.
// Latency: model predicts the outputs of each edge from the inputs sampled at that edge.
// Backpressure: not applicable.
module tb_secuenciador_melodia;
  localparam int TPB      = 4;
  localparam int GAPT     = 2;
  localparam int SONG_LEN = 20 * TPB + 16 * GAPT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] teclas_in = 7'd0;
  logic [6:0] teclas;
  logic       busy;
  logic       done;
  logic [3:0] note_idx;

  secuenciador_melodia #(
    .TICKS_PER_BEAT(TPB),
    .GAP_TICKS(GAPT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .play(play),
    .stop(stop),
    .teclas_in(teclas_in),
    .teclas(teclas),
    .busy(busy),
    .done(done),
    .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: the song as a timeline of note segments followed by gaps.
  int song_note [16] = '{1, 2, 3, 4, 5, 6, 7, 0, 7, 6, 5, 4, 3, 2, 1, 0};
  int song_dur  [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0};

  bit m_busy   = 1'b0;
  bit m_done   = 1'b0;
  int m_t      = 0;
  int m_idx    = 0;
  int m_teclas = 0;

  task automatic lookup(input int t, output int idx, output int tk);
    int r;
    r   = t;
    idx = 15;
    tk  = 0;
    for (int e = 0; e < 16; e++) begin
      int len;
      len = (song_dur[e] + 1) * TPB;
      if (r < len) begin
        idx = e;
        tk  = (song_note[e] == 0) ? 0 : (64 >> (song_note[e] - 1));
        return;
      end
      r -= len;
      if (r < GAPT) begin
        idx = e;
        tk  = 0;
        return;
      end
      r -= GAPT;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_t = 0; m_idx = 0; m_teclas = 0;
    end else begin
      m_done = 1'b0;
      if (stop) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (play) begin
          m_busy = 1'b1;
          m_t    = 0;
        end
      end else begin
        m_t++;
        if (m_t == SONG_LEN) begin
          m_done = 1'b1;
          m_t    = 0;
`ifndef SECUENCIADOR_LOOP_EN
          m_busy = 1'b0;
`endif
        end
      end
      if (m_busy) lookup(m_t, m_idx, m_teclas);
      else begin
        m_idx    = 0;
        m_teclas = int'(teclas_in);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en && !reset) begin
      check("teclas", int'(teclas), m_teclas);
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
      check("note_idx", int'(note_idx), m_idx);
    end
  end

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rest7;
    int long14;

    repeat (3) @(posedge clk);
    #1;
    check("reset_teclas", int'(teclas), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_idx", int'(note_idx), 0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Passthrough while idle.
    teclas_in = 7'b0001000;
    next_edge();
    check("passthrough", int'(teclas), 8);

    // Full song with a re-pulse of play while busy.
    teclas_in = 7'd0;
    next_edge();              // edge 0
    play   = 1'b1;
    rest7  = 0;
    long14 = 0;
    for (int e = 1; e <= 114; e++) begin
      next_edge();
      if (e <= 4)       check("note1", int'(teclas), 64);
      else if (e <= 6)  check("gap1", int'(teclas), 0);
      else if (e <= 10) check("note2", int'(teclas), 32);
      if (busy && note_idx == 4'd7 && teclas == 7'd0) rest7++;
      if (busy && note_idx == 4'd14 && teclas == 7'b1000000) long14++;
      if (e == 112) check("busy_e112", int'(busy), 1);
      if (e == 113) begin
`ifdef SECUENCIADOR_LOOP_EN
        check("loop_busy_e113", int'(busy), 1);
        check("loop_teclas_e113", int'(teclas), 64);
`else
        check("end_busy_e113", int'(busy), 0);
`endif
        check("end_done_e113", int'(done), 1);
        check("end_idx_e113", int'(note_idx), 0);
      end
      if (e == 114) check("done_one_cycle", int'(done), 0);
      play      = (e == 29);
      teclas_in = 7'($urandom);
    end
    check("rest7_cycles", rest7, 10);
    check("long14_cycles", long14, 16);
    stop = 1'b1;
    next_edge();
    stop = 1'b0;

    // Abort at edge 20.
    teclas_in = 7'b0000101;
    next_edge();              // edge 0
    play = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      next_edge();
      if (e == 20) check("abort_busy_before", int'(busy), 1);
      if (e == 21) begin
        check("abort_busy", int'(busy), 0);
        check("abort_teclas", int'(teclas), int'(teclas_in));
        check("abort_done", int'(done), 0);
      end
      if (e == 22) check("abort_done_after", int'(done), 0);
      play = 1'b0;
      stop = (e == 20);
    end

    // play and stop together in idle: no start.
    play = 1'b1;
    stop = 1'b1;
    next_edge();
    check("prio_busy", int'(busy), 0);
    play = 1'b0;
    stop = 1'b0;
    next_edge();
    check("prio_busy_after", int'(busy), 0);

    // Asynchronous reset mid-note.
    play = 1'b1;
    next_edge();
    play = 1'b0;
    next_edge();
    check("pre_reset_teclas", int'(teclas), 64);
    #2 reset = 1'b1;
    #1;
    check("async_reset_teclas", int'(teclas), 0);
    check("async_reset_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;

    // Random stimulus against the model.
    for (int c = 0; c < 700; c++) begin
      next_edge();
      play      = ($urandom_range(0, 15) == 0);
      stop      = ($urandom_range(0, 149) == 0);
      teclas_in = 7'($urandom);
    end
    play = 1'b0;
    stop = 1'b0;
    next_edge();
    next_edge();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
